// File: rtl/lynx_tape_pkg.sv
// Shared types and default timing constants for the Lynx cassette transmitter.
package lynx_tape_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeader,
    StSync,
    StLoad,
    StData,
    StTrailer
  } tape_state_e;

  // Defaults assume a 4 MHz clock enable.
  localparam int unsigned DefHalf0   = 833;
  localparam int unsigned DefHalf1   = 1666;
  localparam int unsigned DefLeader  = 768;
  localparam int unsigned DefTrailer = 32;
  localparam int unsigned DefCw      = 12;

endpackage

// File: rtl/tape_bit_gen.sv
// Square-wave bit-cycle generator: high for one half-period, low for one half-period.
module tape_bit_gen
  import lynx_tape_pkg::*;
#(
  parameter int unsigned HALF0 = DefHalf0,
  parameter int unsigned HALF1 = DefHalf1,
  parameter int unsigned CW    = DefCw
) (
  input  logic clock24,
  input  logic reset,
  input  logic ce,
  input  logic go,
  input  logic clear,
  input  logic bit_val,
  output logic level,
  output logic bit_end
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] half_m1;
  logic          phase_q, phase_d;
  logic          half_end;

  always_comb begin
    half_m1  = bit_val ? CW'(HALF1 - 1) : CW'(HALF0 - 1);
    half_end = (cnt_q == half_m1);
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    bit_end  = ce & go & ~clear & phase_q & half_end;
    level    = go & ~phase_q;
    if (ce) begin
      if (clear) begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (go) begin
        if (half_end) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock24) begin
    if (!reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // The counter must reach the longer half-period without wrapping.
  always_ff @(posedge clock24) begin
    assert (HALF1 < (32'd1 << CW) && HALF0 < (32'd1 << CW));
  end

endmodule

// File: rtl/lynx_tape_player.sv
// Lynx tape transmitter: leader, sync bit, MSB-first data bytes and trailer on the ear line.
module lynx_tape_player
  import lynx_tape_pkg::*;
#(
  parameter int unsigned HALF0   = DefHalf0,
  parameter int unsigned HALF1   = DefHalf1,
  parameter int unsigned LEADER  = DefLeader,
  parameter int unsigned TRAILER = DefTrailer,
  parameter int unsigned CW      = DefCw
) (
  input  logic       clock24,
  input  logic       reset,
  input  logic       ce,
  input  logic       start,
  input  logic       stop,
  input  logic [7:0] inData,
  input  logic       inValid,
  input  logic       inLast,
  output logic       inReady,
  output logic       level,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int unsigned CycMax = (LEADER > TRAILER) ? LEADER : TRAILER;
  localparam int unsigned CycW   = (CycMax > 2) ? $clog2(CycMax) : 1;
  localparam logic [CycW-1:0] LeaderM1  = CycW'(LEADER - 1);
  localparam logic [CycW-1:0] TrailerM1 = CycW'(TRAILER - 1);

  tape_state_e     state_q, state_d;
  logic [CycW-1:0] cyc_q, cyc_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            last_q, last_d;
  logic            waiting_q, waiting_d;
  logic            done_q, done_d;
  logic            underrun_q, underrun_d;
  logic            go, clear, bit_val, bit_end;

  tape_bit_gen #(
    .HALF0(HALF0),
    .HALF1(HALF1),
    .CW   (CW)
  ) u_bit_gen (
    .clock24(clock24),
    .reset  (reset),
    .ce     (ce),
    .go     (go),
    .clear  (clear),
    .bit_val(bit_val),
    .level  (level),
    .bit_end(bit_end)
  );

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    last_d     = last_q;
    waiting_d  = waiting_q;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    clear      = 1'b0;
    go         = (state_q == StLeader) || (state_q == StSync) ||
                 (state_q == StData) || (state_q == StTrailer);
    bit_val    = (state_q == StSync) || ((state_q == StData) && shift_q[7]);
    inReady    = (state_q == StLoad);
    busy       = (state_q != StIdle);

    if (ce) begin
      if ((state_q != StIdle) && stop) begin
        state_d   = StIdle;
        clear     = 1'b1;
        cyc_d     = '0;
        idx_d     = '0;
        shift_d   = '0;
        last_d    = 1'b0;
        waiting_d = 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start && !stop) begin
              state_d = StLeader;
              cyc_d   = '0;
            end
          end
          StLeader: begin
            if (bit_end) begin
              if (cyc_q == LeaderM1) begin
                cyc_d   = '0;
                state_d = StSync;
              end else begin
                cyc_d = cyc_q + CycW'(1);
              end
            end
          end
          StSync: begin
            if (bit_end) state_d = StLoad;
          end
          StLoad: begin
            if (inValid) begin
              shift_d   = inData;
              last_d    = inLast;
              idx_d     = 3'd7;
              waiting_d = 1'b0;
              state_d   = StData;
            end else if (!waiting_q) begin
              // Flag the starvation once per visit, not on every tick spent waiting.
              underrun_d = 1'b1;
              waiting_d  = 1'b1;
            end
          end
          StData: begin
            if (bit_end) begin
              if (idx_q == 3'd0) begin
                state_d = last_q ? StTrailer : StLoad;
                cyc_d   = '0;
              end else begin
                idx_d   = idx_q - 3'd1;
                shift_d = {shift_q[6:0], 1'b0};
              end
            end
          end
          StTrailer: begin
            if (bit_end) begin
              if (cyc_q == TrailerM1) begin
                cyc_d   = '0;
                done_d  = 1'b1;
                state_d = StIdle;
              end else begin
                cyc_d = cyc_q + CycW'(1);
              end
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clock24) begin
    if (!reset) begin
      state_q    <= StIdle;
      cyc_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      last_q     <= 1'b0;
      waiting_q  <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      last_q     <= last_d;
      waiting_q  <= waiting_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign done     = done_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_lynx_tape_player.sv
// Randomized self-checking bench for lynx_tape_player against a tick-stream model.
module tb_lynx_tape_player;

  localparam int unsigned H0 = 3;
  localparam int unsigned H1 = 6;
  localparam int unsigned LD = 4;
  localparam int unsigned TR = 2;

  logic       clock24 = 1'b0;
  logic       reset   = 1'b0;
  logic       ce      = 1'b0;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic [7:0] inData  = 8'h00;
  logic       inValid = 1'b0;
  logic       inLast  = 1'b0;
  logic       inReady, level, busy, done, underrun;

  int n_vec = 0;
  int n_err = 0;

  typedef logic [7:0] bytes_t[$];
  typedef int ints_t[$];
  // Expected outputs for one ce tick: {level, busy, inReady, done, underrun}.
  typedef struct packed {
    logic lvl;
    logic bsy;
    logic rdy;
    logic dne;
    logic und;
  } exp_t;

  exp_t exp_q[$];
  int   bit3_tick;

  lynx_tape_player #(
    .HALF0  (H0),
    .HALF1  (H1),
    .LEADER (LD),
    .TRAILER(TR),
    .CW     (12)
  ) dut (
    .clock24 (clock24),
    .reset   (reset),
    .ce      (ce),
    .start   (start),
    .stop    (stop),
    .inData  (inData),
    .inValid (inValid),
    .inLast  (inLast),
    .inReady (inReady),
    .level   (level),
    .busy    (busy),
    .done    (done),
    .underrun(underrun)
  );

  always #5 clock24 = ~clock24;

  initial begin
    #600000;
    $display("FAIL watchdog: bench still running, required to finish");
    $fatal(1);
  end

  function automatic void push_n(input int n, input exp_t e);
    repeat (n) exp_q.push_back(e);
  endfunction

  function automatic void push_bit(input logic b);
    int h;
    h = b ? H1 : H0;
    push_n(h, 5'b11000);
    push_n(h, 5'b01000);
  endfunction

  // One entry per ce tick from the start edge on; w[j] = starved LOAD ticks before byte j.
  function automatic void build_model(input bytes_t d, input ints_t w, input int stop_at);
    exp_q.delete();
    bit3_tick = -1;
    repeat (LD) push_bit(1'b0);
    push_bit(1'b1);
    foreach (d[j]) begin
      for (int t = 0; t <= w[j]; t++) exp_q.push_back((t == 1) ? 5'b01101 : 5'b01100);
      for (int b = 7; b >= 0; b--) begin
        if (j == 0 && b == 3) bit3_tick = exp_q.size();
        push_bit(d[j][b]);
      end
    end
    repeat (TR) push_bit(1'b0);
    exp_q.push_back(5'b00010);
    if (stop_at > 0) begin
      while (exp_q.size() > stop_at) void'(exp_q.pop_back());
      repeat (3) exp_q.push_back(5'b00000);
    end
  endfunction

  // Plays one block; stop_at > 0 asserts stop on the ce edge that ends tick stop_at-1.
  task automatic play(input bytes_t d, input ints_t w, input int div, input int stop_at,
                      output int rdy_clks, output int und_cnt, output int done_cnt);
    int   k, sub, bi, wl;
    bit   nce, acc;
    exp_t e;
    logic [4:0] obs, want;
    build_model(d, w, stop_at);
    rdy_clks = 0;
    und_cnt  = 0;
    done_cnt = 0;
    k  = 0;
    sub = 0;
    bi = 0;
    wl = w[0];
    ce      = 1'b1;
    start   = 1'b1;
    stop    = 1'b0;
    inValid = 1'($urandom);
    inData  = 8'($urandom);
    inLast  = 1'($urandom);
    @(posedge clock24);
    #1;
    while (k < exp_q.size()) begin
      e    = exp_q[k];
      obs  = {level, busy, inReady, done, underrun};
      want = (sub == 0) ? e : {e.lvl, e.bsy, e.rdy, 2'b00};
      n_vec++;
      if (obs !== want) begin
        n_err++;
        $display("FAIL play tick %0d clk %0d {level,busy,inReady,done,underrun}: got %b want %b",
                 k, sub, obs, want);
      end
      if (inReady === 1'b1) rdy_clks++;
      if (underrun === 1'b1) und_cnt++;
      if (done === 1'b1) done_cnt++;
      nce     = (sub == div - 1);
      acc     = 1'b0;
      ce      = nce;
      start   = 1'($urandom);
      stop    = 1'($urandom);
      inValid = 1'($urandom);
      inData  = 8'($urandom);
      inLast  = 1'($urandom);
      if (nce) begin
        start = e.bsy ? start : 1'b0;
        stop  = (k == stop_at - 1);
        if (inReady === 1'b1 && bi < d.size()) begin
          if (wl > 0) begin
            inValid = 1'b0;
            wl--;
          end else begin
            inValid = 1'b1;
            inData  = d[bi];
            inLast  = (bi == d.size() - 1);
            acc     = 1'b1;
          end
        end
      end
      @(posedge clock24);
      #1;
      if (nce) begin
        k++;
        sub = 0;
        if (acc) begin
          bi++;
          if (bi < d.size()) wl = w[bi];
        end
      end else begin
        sub++;
      end
    end
    start   = 1'b0;
    stop    = 1'b0;
    inValid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ce    = 1'b1;
    start = 1'b1;
    repeat (3) begin
      @(posedge clock24);
      #1;
      n_vec++;
      if ({level, busy, inReady, done, underrun} !== 5'b00000) begin
        n_err++;
        $display("FAIL reset_hold outputs: got %b want 00000",
                 {level, busy, inReady, done, underrun});
      end
    end
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock24);
    #1;
    n_vec++;
    if ({level, busy, inReady, done, underrun} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_release outputs: got %b want 00000",
               {level, busy, inReady, done, underrun});
    end
  endtask

  task automatic test_single_byte(input int div);
    bytes_t d;
    ints_t  w;
    int     r, u, dn;
    d = '{8'hA5};
    w = '{0};
    play(d, w, div, 0, r, u, dn);
    n_vec++;
    if (dn !== 1 || u !== 0 || r !== div) begin
      n_err++;
      $display("FAIL single_byte div %0d done/underrun/ready clocks: got %0d/%0d/%0d want 1/0/%0d",
               div, dn, u, r, div);
    end
  endtask

  task automatic test_back_to_back();
    bytes_t d;
    ints_t  w;
    int     r, u, dn;
    d = '{8'h00, 8'hFF};
    w = '{0, 0};
    play(d, w, 1, 0, r, u, dn);
    n_vec++;
    if (r !== 2 || u !== 0 || dn !== 1) begin
      n_err++;
      $display("FAIL back_to_back ready/underrun/done: got %0d/%0d/%0d want 2/0/1", r, u, dn);
    end
  endtask

  task automatic test_underrun();
    bytes_t d;
    ints_t  w;
    int     r, u, dn;
    d = '{8'h3C};
    w = '{10};
    play(d, w, 1, 0, r, u, dn);
    n_vec++;
    if (u !== 1 || r !== 11) begin
      n_err++;
      $display("FAIL underrun pulses/ready clocks: got %0d/%0d want 1/11", u, r);
    end
  endtask

  task automatic test_stop_and_replay();
    bytes_t d;
    ints_t  w;
    int     r, u, dn, s;
    d = '{8'h96, 8'h5A};
    w = '{0, 0};
    build_model(d, w, 0);
    s = bit3_tick + 2;
    play(d, w, 1, s, r, u, dn);
    n_vec++;
    if (dn !== 0) begin
      n_err++;
      $display("FAIL stop done pulses: got %0d want 0", dn);
    end
    d = '{8'($urandom)};
    w = '{1};
    play(d, w, 1, 0, r, u, dn);
    n_vec++;
    if (dn !== 1 || u !== 1) begin
      n_err++;
      $display("FAIL replay done/underrun: got %0d/%0d want 1/1", dn, u);
    end
  endtask

  task automatic test_start_stop_idle();
    ce    = 1'b1;
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) begin
      @(posedge clock24);
      #1;
      n_vec++;
      if ({level, busy, inReady, done, underrun} !== 5'b00000) begin
        n_err++;
        $display("FAIL start_stop_idle outputs: got %b want 00000",
                 {level, busy, inReady, done, underrun});
      end
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_random();
    bytes_t d;
    ints_t  w;
    int     r, u, dn, n, div, sz, s;
    for (int it = 0; it < 8; it++) begin
      d.delete();
      w.delete();
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        d.push_back(8'($urandom));
        w.push_back(($urandom % 2 == 0) ? 0 : int'($urandom_range(1, 4)));
      end
      div = $urandom_range(1, 3);
      build_model(d, w, 0);
      sz = exp_q.size();
      s  = ($urandom % 3 == 0) ? int'($urandom_range(1, sz - 1)) : 0;
      play(d, w, div, s, r, u, dn);
      n_vec++;
      if (dn !== ((s == 0) ? 1 : 0)) begin
        n_err++;
        $display("FAIL random iter %0d done pulses: got %0d want %0d", it, dn, (s == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reset_mid();
    ce    = 1'b1;
    start = 1'b1;
    @(posedge clock24);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock24);
    #1;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid busy before reset: got %b want 1", busy);
    end
    reset = 1'b0;
    ce    = 1'b0;
    @(posedge clock24);
    #1;
    reset = 1'b1;
    ce    = 1'b1;
    n_vec++;
    if ({level, busy, inReady, done, underrun} !== 5'b00000) begin
      n_err++;
      $display("FAIL reset_mid outputs: got %b want 00000", {level, busy, inReady, done, underrun});
    end
    @(posedge clock24);
    #1;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid busy after release: got %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte(1);
    test_back_to_back();
    test_underrun();
    test_stop_and_replay();
    test_single_byte(4);
    test_start_stop_idle();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
